updown_counter_param: RTL

Parametrised up/down counter: the next generation of the team's fixed 4-bit up/down counter. Adds configurable width, modulus, step size, a clock-enable prescaler, synchronous parallel load, and registered overflow/underflow pulses. Intended as the general event/position counter for timers, address generators and test sequencing across the design.

---
 rtl/udc_pkg.sv | 8 +
 rtl/udc_prescaler.sv | 25 ++
 rtl/updown_counter_param.sv | 64 ++++++
 3 files changed

// File: rtl/udc_pkg.sv
// udc_pkg: shared direction constants and prescaler phase-width helper for updown_counter_param
package udc_pkg;
    localparam logic UDC_UP = 1'b1;
    localparam logic UDC_DN = 1'b0;
    function automatic int udc_phase_w(input int div);
        return div > 1 ? $clog2(div) : 1;
    endfunction
endpackage

// File: rtl/udc_prescaler.sv
// udc_prescaler: divides enabled cycles by DIV into a one-cycle tick, cleared by clr
module udc_prescaler
    import udc_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    if (DIV == 1) begin : g_bypass
        logic unused_ok;
        assign unused_ok = ^{clk, rst, clr};
        assign tick = en;
    end else begin : g_div
        localparam int PW = udc_phase_w(DIV);
        logic [PW-1:0] phase;
        assign tick = en && phase == PW'(DIV - 1);
        always_ff @(posedge clk)
            if (rst || clr) phase <= '0;
            else if (en) phase <= tick ? '0 : phase + PW'(1);
    end
endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: modulo/step/prescaled up-down counter; define UDC_SATURATE_EN to clamp instead of wrap
module updown_counter_param
    import udc_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int STEP    = 1,
    parameter int DIV     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf,
    output logic             at_max,
    output logic             at_min
);
    localparam logic [WIDTH:0] MAXE = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH:0] STEPE = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0] MODE = MAXE + (WIDTH + 1)'(1);
    logic             tick;
    logic [WIDTH:0]   cnt_e, sum;
    logic             over, under;
    logic [WIDTH-1:0] up_val, dn_val, ld_val;
    udc_prescaler #(.DIV(DIV)) u_pre (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (load),
        .tick(tick)
    );
    assign cnt_e = {1'b0, count};
    assign sum   = cnt_e + STEPE;
    assign over  = sum > MAXE;
    assign under = cnt_e < STEPE;
`ifdef UDC_SATURATE_EN
    assign up_val = over ? WIDTH'(MAX_VAL) : sum[WIDTH-1:0];
    assign dn_val = under ? '0 : WIDTH'(cnt_e - STEPE);
`else
    assign up_val = over ? WIDTH'(sum - MODE) : sum[WIDTH-1:0];
    assign dn_val = under ? WIDTH'(cnt_e + MODE - STEPE) : WIDTH'(cnt_e - STEPE);
`endif
    assign ld_val = {1'b0, load_val} > MAXE ? WIDTH'(MAX_VAL) : load_val;
    assign at_max = count == WIDTH'(MAX_VAL);
    assign at_min = count == '0;
    always_ff @(posedge clk)
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (load) begin
            count <= ld_val;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= tick ? (up_down == UDC_UP ? up_val : dn_val) : count;
            ovf   <= tick && up_down == UDC_UP && over;
            unf   <= tick && up_down == UDC_DN && under;
        end
endmodule
